// File: rtl/my_pkg.sv
// Shared issue-stage types: instruction/execution-unit enums and the issue token
// passed from operand fetch to execute.
package my_pkg;

  localparam int TOKEN_TAG_W  = 4;
  localparam int TOKEN_DATA_W = 32;

  typedef enum logic [2:0] {
    OP0, OP1, OP2, OP3, OP4, OP5, OP6, OP7
  } instruction_type;

  typedef enum logic [1:0] {
    bypass, alu, mul, lsu
  } xu;

  typedef struct packed {
    instruction_type         i;
    xu                       xu_sel;
    logic [TOKEN_TAG_W-1:0]  tag;
    logic [TOKEN_DATA_W-1:0] opA;
    logic [TOKEN_DATA_W-1:0] opB;
    logic [TOKEN_DATA_W-1:0] opC;
    logic [TOKEN_DATA_W-1:0] NPC;
  } issue_token_t;

  localparam issue_token_t ISSUE_TOKEN_RST = '{
    i: OP0, xu_sel: bypass, tag: '0, opA: '0, opB: '0, opC: '0, NPC: '0
  };

endpackage

// File: rtl/issue_token_queue.sv
// Elastic circular token queue between operand fetch and execute, with tag-based
// flush on taken jumps. Optional zero-latency empty-queue forwarding: QUEUE_BYPASS_EN.
module issue_token_queue
  import my_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = TOKEN_TAG_W,
  parameter int DATA_W = TOKEN_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  issue_token_t           in_token,
  output logic                   out_valid,
  input  logic                   out_ready,
  output issue_token_t           out_token,
  input  logic                   flush,
  input  logic [TAG_W-1:0]       flush_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  // Raw entry width derived from the parameters; must equal the packed token width
  localparam int TOK_W = 3 + 2 + TAG_W + 4 * DATA_W;

  logic [DEPTH-1:0][TOK_W-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        empty, full, push, pop_mem, tag_hit;
  logic                        byp, byp_take, wr_en;
  issue_token_t                head;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign head     = issue_token_t'(mem[rd_ptr]);
  assign in_ready = !full | out_ready | flush;
  assign push     = in_valid & in_ready;
  assign pop_mem  = out_ready & !empty;
  assign tag_hit  = (in_token.tag == flush_tag);

`ifdef QUEUE_BYPASS_EN
  assign byp = empty & in_valid & !flush & reset;
`else
  assign byp = 1'b0;
`endif
  assign byp_take = byp & out_ready;

  assign out_valid = !empty | byp;
  assign out_token = byp ? in_token : head;

  // During flush only a token already carrying the new stream tag survives
  assign wr_en = push & (flush ? tag_hit : !byp_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= {DEPTH{TOK_W'(ISSUE_TOKEN_RST)}};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= in_token;
      wr_ptr <= wr_ptr + PW'(wr_en);
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= CW'(wr_en);
      end else begin
        rd_ptr <= rd_ptr + PW'(pop_mem);
        unique case ({wr_en, pop_mem})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/issue_token_queue.md
Name: issue_token_queue

Overview:
Parametrised elastic queue for issue tokens between operand fetch (OPF) and execute.
- Replaces the fixed TOKENS-deep shift register; adds valid/ready flow control, occupancy reporting and tag-based flush on taken jumps.
- Sits between OPF outputs (i, xu, tag, opA/opB/opC, NPC) and execute inputs; one token per cycle maximum in each direction.

Parameters:
DEPTH, 2, number of token entries (power of two, ≥2)
TAG_W, 4, width of the instruction stream tag
DATA_W, 32, width of opA/opB/opC/NPC

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous active-low reset
in_valid  in  1  OPF presents a token
in_ready  out  1  queue accepts the token this cycle
in_token  in  issue_token_t  {i, xu, tag, opA, opB, opC, NPC} from OPF
out_valid  out  1  head token available to execute
out_ready  in  1  execute consumes head this cycle
out_token  out  issue_token_t  head token to execute
flush  in  1  taken jump retired this cycle
flush_tag  in  TAG_W  new stream tag after the jump
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_token={i:OP0, xu:bypass, all else 0}; in_ready=1 once reset releases.
- Storage: circular buffer of DEPTH entries; pointers wrap DEPTH-1→0; count tracked explicitly, so full is count==DEPTH and empty is count==0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count<DEPTH) | out_ready. Simultaneous push+pop when full is legal; count stays DEPTH.
- out_valid = (count!=0). out_token = entry[rd_ptr] (registered storage, combinational read).
- Latency without the feature: token pushed in cycle N is visible at out_token in cycle N+1.
- Count update: push&!pop → +1; pop&!push → −1; both or neither → unchanged.
- Flush (flush=1 at edge):
  - All stored entries are discarded: count←0, rd_ptr←wr_ptr.
  - A same-cycle input token is written only if in_token.tag==flush_tag (new-stream token); otherwise it is dropped but still acknowledged (in_ready=1 during flush).
  - A pop in the flush cycle is honoured for the current head (execute already sampled it); flush dominates all pointer and count updates.
- Tokens with stale tags are never re-examined after flush; tag comparison happens only in the flush cycle.
- in_token must be stable while in_valid & !in_ready (OPF contract). No state change when in_valid=0 and out_ready=0.
- Reset asserted mid-operation clears everything immediately; no partial token survives.

Optional Feature:
QUEUE_BYPASS_EN
- Defined: when count==0 and in_valid=1 and flush=0, in_token is forwarded combinationally to out_token with out_valid=1 (zero latency).
  - If out_ready=1 the same cycle, the token is not written; count stays 0.
  - Otherwise the token is stored as normal.
- Undefined: minimum latency is 1 cycle and out_valid depends only on count.

Decomposition:
- my_pkg gains issue_token_t, a packed struct {instruction_type i; xu xu_sel; logic[TAG_W-1:0] tag; logic[DATA_W-1:0] opA, opB, opC, NPC}, using the existing instruction_type and xu enums.
- my_pkg also gains a localparam for the reset token value (i=OP0, xu=bypass).
- No sub-module: pointers, count and storage stay in one flat module. TOP instantiates issue_token_queue #(DEPTH) in place of the shift-register queue.

Test Plan:
- Reset with out_ready=0, push 3 tokens with tags 1,1,1 (DEPTH=2) → first two accepted, count=2, in_ready=0 on the third; raise out_ready → tokens pop in order, count stays 2 during overlap, then drains to 0.
- Continuous in_valid=out_ready=1, 100 tokens with opA=0..99 → out_token.opA sequence 0..99 with 1-cycle latency, no drops, count≤1.
- Fill to DEPTH=4 with tag 2, then flush=1, flush_tag=3 with in_token.tag=3 → count=1 next cycle, head opA equals the new token's opA; repeat with in_token.tag=2 → count=0.
- Wrap-around: DEPTH=4, push/pop interleaved over 10 tokens → pointers wrap, in-order output, count never exceeds 4.
- Assert reset mid-stream with count=3 → out_valid=0, out_token.i=OP0 and count=0 immediately, without waiting for a clock edge.
- With QUEUE_BYPASS_EN, empty queue, in_valid=out_ready=1, opA=0xDEADBEEF → out_token.opA=0xDEADBEEF same cycle, count remains 0.
